// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, flit type encoding, head-field layout
// and router address format, used by both the packetizer and route computation.
package noc_pkg;

    localparam int FLIT_W        = 16;
    localparam int ADDR_W        = 8;
    localparam int LEN_W         = 4;
    localparam int PAYLOAD_W     = 14;
    localparam int TYPE_LSB      = 14;
    localparam int HEAD_DEST_LSB = 6;
    localparam int HEAD_LEN_LSB  = 2;

    typedef enum logic [1:0] {
        FT_BODY      = 2'b00,
        FT_HEAD      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } noc_addr_t;

    function automatic logic [FLIT_W-1:0] make_head(input flit_type_e ftype,
                                                    input noc_addr_t dest,
                                                    input logic [LEN_W-1:0] len);
        return {ftype, dest, len, 2'b00};
    endfunction

    function automatic logic [FLIT_W-1:0] make_payload(input flit_type_e ftype,
                                                       input logic [PAYLOAD_W-1:0] data);
        return {ftype, data};
    endfunction

endpackage

// File: rtl/ni_credit_counter.sv
// Credit counter tracking free slots in the router's local input queue;
// flags a sticky error if the router returns more credits than slots exist.
module ni_credit_counter #(
    parameter int BUF_DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic consume,
    input  logic credit_i,
    output logic avail,
    output logic err
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] ZERO = CW'(0);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count_r;
    logic          err_r;

    // Count update; a simultaneous send and credit cancel out
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= FULL;
            err_r   <= 1'b0;
        end else begin
            case ({consume, credit_i})
                2'b10: begin
                    if (count_r != ZERO) begin
                        count_r <= count_r - ONE;
                    end else begin
                        count_r <= count_r;
                    end
                end
                2'b01: begin
                    if (count_r == FULL) begin
                        err_r <= 1'b1;
                    end else begin
                        count_r <= count_r + ONE;
                    end
                end
                default: count_r <= count_r;
            endcase
        end
    end

    assign avail = (count_r != ZERO);
    assign err   = err_r;

endmodule

// File: rtl/ni_packetizer.sv
// NI transmit side: turns a (dest, len) descriptor plus payload words into
// head/body/tail flits for the router local queue under credit flow control.
module ni_packetizer
    import noc_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int MAX_LEN   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 msg_valid_i,
    output logic                 msg_ready_o,
    input  logic [ADDR_W-1:0]    msg_dest_i,
    input  logic [LEN_W-1:0]     msg_len_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic [PAYLOAD_W-1:0] data_i,
    output logic [FLIT_W-1:0]    flit_o,
    output logic                 flit_valid_o,
    input  logic                 credit_i,
    output logic                 credit_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAD = 2'b01,
        S_BODY = 2'b10
    } state_e;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    state_e             state_r, state_s;
    noc_addr_t          dest_r, dest_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic [LEN_W-1:0]   rem_r, rem_s;
    logic               send_s;
    logic [FLIT_W-1:0]  flit_s;
    logic               avail_s;

    ni_credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .consume  (send_s),
        .credit_i (credit_i),
        .avail    (avail_s),
        .err      (credit_err_o)
    );

    // Next-state, flit assembly and handshake outputs
    always_comb begin
        state_s      = state_r;
        dest_s       = dest_r;
        len_s        = len_r;
        rem_s        = rem_r;
        send_s       = 1'b0;
        flit_s       = {FLIT_W{1'b0}};
        msg_ready_o  = (state_r == S_IDLE);
        data_ready_o = (state_r == S_BODY) && avail_s;
        case (state_r)
            S_IDLE: begin
                if (msg_valid_i) begin
                    dest_s  = msg_dest_i;
                    len_s   = (msg_len_i > MAX_LEN_L) ? MAX_LEN_L : msg_len_i;
                    state_s = S_HEAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HEAD: begin
                if (avail_s) begin
                    send_s = 1'b1;
                    if (len_r == 4'd0) begin
                        flit_s  = make_head(FT_HEAD_TAIL, dest_r, len_r);
                        state_s = S_IDLE;
                    end else begin
                        flit_s  = make_head(FT_HEAD, dest_r, len_r);
                        rem_s   = len_r;
                        state_s = S_BODY;
                    end
                end else begin
                    state_s = S_HEAD;
                end
            end
            S_BODY: begin
                // data_ready already folds in credit availability
                if (data_valid_i && data_ready_o) begin
                    send_s = 1'b1;
                    rem_s  = rem_r - 4'd1;
                    if (rem_r == 4'd1) begin
                        flit_s  = make_payload(FT_TAIL, data_i);
                        state_s = S_IDLE;
                    end else begin
                        flit_s  = make_payload(FT_BODY, data_i);
                        state_s = S_BODY;
                    end
                end else begin
                    state_s = S_BODY;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, descriptor latches and registered flit output
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= S_IDLE;
            dest_r       <= '0;
            len_r        <= 4'd0;
            rem_r        <= 4'd0;
            flit_o       <= {FLIT_W{1'b0}};
            flit_valid_o <= 1'b0;
        end else begin
            state_r      <= state_s;
            dest_r       <= dest_s;
            len_r        <= len_s;
            rem_r        <= rem_s;
            flit_valid_o <= send_s;
            if (send_s) begin
                flit_o <= flit_s;
            end else begin
                flit_o <= flit_o;
            end
        end
    end

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: directed scenarios with cycle-exact checks, then
// randomized traffic compared against a flit-sequence reference model.
module tb_ni_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_dest;
    logic [3:0]  msg_len;
    logic        data_valid;
    logic        data_ready;
    logic [13:0] data;
    logic [15:0] flit;
    logic        flit_valid;
    logic        credit;
    logic        credit_err;

    int total = 0;
    int bad   = 0;

    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int          occ;
    int          max_occ;

    always #5 clk = ~clk;

    ni_packetizer #(.BUF_DEPTH(4), .MAX_LEN(15)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .msg_valid_i  (msg_valid),
        .msg_ready_o  (msg_ready),
        .msg_dest_i   (msg_dest),
        .msg_len_i    (msg_len),
        .data_valid_i (data_valid),
        .data_ready_o (data_ready),
        .data_i       (data),
        .flit_o       (flit),
        .flit_valid_o (flit_valid),
        .credit_i     (credit),
        .credit_err_o (credit_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; msg_valid = 1'b0; data_valid = 1'b0; credit = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; msg_valid = 1'b0; data_valid = 1'b0; credit = 1'b0;
        msg_dest = 8'h00; msg_len = 4'd0; data = 14'h0;
        tick(); tick();
        total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL reset_msg_ready got=%b want=1", msg_ready); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_data_ready got=%b want=0", data_ready); end
        total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL reset_flit_valid got=%b want=0", flit_valid); end
        total++; if (flit !== 16'h0000) begin bad++; $display("FAIL reset_flit got=%h want=0000", flit); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL reset_credit_err got=%b want=0", credit_err); end
        total++; if (dut.u_credit.count_r !== 3'd4) begin bad++; $display("FAIL reset_count got=%0d want=4", dut.u_credit.count_r); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        msg_valid = 1'b1; msg_dest = 8'h23; msg_len = 4'd0;
        total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL single_accept got=%b want=1", msg_ready); end
        tick();
        msg_valid = 1'b0;
        total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", flit_valid); end
        total++; if (msg_ready !== 1'b0) begin bad++; $display("FAIL single_busy got=%b want=0", msg_ready); end
        tick();
        total++; if (flit_valid !== 1'b1 || flit !== 16'hC8C0) begin bad++; $display("FAIL single_flit got=%b/%h want=1/c8c0", flit_valid, flit); end
        total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL single_ready_again got=%b want=1", msg_ready); end
        credit = 1'b1;
        tick();
        credit = 1'b0;
        total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL single_one_cycle got=%b want=0", flit_valid); end
        total++; if (dut.u_credit.count_r !== 3'd4) begin bad++; $display("FAIL single_count got=%0d want=4", dut.u_credit.count_r); end
    endtask

    task automatic test_multi();
        logic [15:0] exp_f [4];
        exp_f[0] = 16'h448C; exp_f[1] = 16'h0001; exp_f[2] = 16'h0002; exp_f[3] = 16'h8003;
        msg_valid = 1'b1; msg_dest = 8'h12; msg_len = 4'd3;
        tick();
        msg_valid = 1'b0;
        data_valid = 1'b1; data = 14'h3FFF;
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL multi_head_data_ready got=%b want=0", data_ready); end
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (flit_valid !== 1'b1 || flit !== exp_f[k]) begin
                bad++; $display("FAIL multi_flit%0d got=%b/%h want=1/%h", k, flit_valid, flit, exp_f[k]);
            end
            if (k < 3) begin
                data_valid = 1'b1; data = 14'(k + 1);
            end else begin
                data_valid = 1'b0;
            end
        end
        total++; if (dut.u_credit.count_r !== 3'd0) begin bad++; $display("FAIL multi_count got=%0d want=0", dut.u_credit.count_r); end
        total++; if (msg_ready !== 1'b1) begin bad++; $display("FAIL multi_idle got=%b want=1", msg_ready); end
    endtask

    task automatic test_starve();
        logic [7:0] d;
        d = 8'($urandom);
        msg_valid = 1'b1; msg_dest = d; msg_len = 4'd2;
        tick();
        msg_valid = 1'b0;
        data_valid = 1'b1; data = 14'($urandom);
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (flit_valid !== 1'b0 || data_ready !== 1'b0) begin
                bad++; $display("FAIL starve_stall%0d got=%b/%b want=0/0", k, flit_valid, data_ready);
            end
        end
        credit = 1'b1;
        tick();
        credit = 1'b0;
        total++; if (dut.u_credit.count_r !== 3'd1) begin bad++; $display("FAIL starve_count1 got=%0d want=1", dut.u_credit.count_r); end
        tick();
        total++; if (flit_valid !== 1'b1 || flit !== {2'b01, d, 4'd2, 2'b00}) begin bad++; $display("FAIL starve_head got=%b/%h want=1/%h", flit_valid, flit, {2'b01, d, 4'd2, 2'b00}); end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (flit_valid !== 1'b0 || data_ready !== 1'b0) begin
                bad++; $display("FAIL starve_one_only%0d got=%b/%b want=0/0", k, flit_valid, data_ready);
            end
        end
        data_valid = 1'b0;
    endtask

    task automatic test_same_cycle();
        do_reset();
        msg_valid = 1'b1; msg_dest = 8'($urandom); msg_len = 4'd1;
        tick();
        msg_valid = 1'b0;
        tick();
        data_valid = 1'b1; data = 14'($urandom);
        tick();
        data_valid = 1'b0;
        total++; if (dut.u_credit.count_r !== 3'd2) begin bad++; $display("FAIL same_pre_count got=%0d want=2", dut.u_credit.count_r); end
        msg_valid = 1'b1; msg_dest = 8'h5A; msg_len = 4'd0;
        tick();
        msg_valid = 1'b0;
        credit = 1'b1;
        tick();
        credit = 1'b0;
        total++; if (dut.u_credit.count_r !== 3'd2) begin bad++; $display("FAIL same_count got=%0d want=2", dut.u_credit.count_r); end
        total++; if (flit_valid !== 1'b1 || flit !== 16'hD680) begin bad++; $display("FAIL same_flit got=%b/%h want=1/d680", flit_valid, flit); end
    endtask

    task automatic test_credit_err();
        credit = 1'b1;
        tick(); tick();
        credit = 1'b0;
        total++; if (dut.u_credit.count_r !== 3'd4 || credit_err !== 1'b0) begin bad++; $display("FAIL err_refill got=%0d/%b want=4/0", dut.u_credit.count_r, credit_err); end
        credit = 1'b1;
        tick();
        credit = 1'b0;
        total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", credit_err); end
        total++; if (dut.u_credit.count_r !== 3'd4) begin bad++; $display("FAIL err_count got=%0d want=4", dut.u_credit.count_r); end
        tick(); tick(); tick();
        total++; if (credit_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", credit_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        msg_valid = 1'b1; msg_dest = 8'h77; msg_len = 4'd3;
        tick();
        msg_valid = 1'b0;
        tick();
        data_valid = 1'b1; data = 14'h0ABC;
        tick();
        data_valid = 1'b0;
        rst = 1'b1;
        tick();
        total++; if (msg_ready !== 1'b1 || data_ready !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b/%b want=1/0", msg_ready, data_ready); end
        total++; if (flit_valid !== 1'b0) begin bad++; $display("FAIL mid_flit_valid got=%b want=0", flit_valid); end
        total++; if (dut.u_credit.count_r !== 3'd4 || credit_err !== 1'b0) begin bad++; $display("FAIL mid_credits got=%0d/%b want=4/0", dut.u_credit.count_r, credit_err); end
        rst = 1'b0;
        msg_valid = 1'b1; msg_dest = 8'h23; msg_len = 4'd0;
        tick();
        msg_valid = 1'b0;
        tick();
        total++; if (flit_valid !== 1'b1 || flit !== 16'hC8C0) begin bad++; $display("FAIL mid_restart got=%b/%h want=1/c8c0", flit_valid, flit); end
        tick();
    endtask

    // Router side of the random test: capture flits, occupy and randomly drain the queue
    task automatic router_step(input bit force_pop);
        if (flit_valid) begin
            got_q.push_back(flit);
            occ++;
            if (occ > max_occ) max_occ = occ;
        end
        credit = 1'b0;
        if (occ > 0 && (force_pop || $urandom_range(0, 2) == 0)) begin
            credit = 1'b1;
            occ--;
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [3:0]  l;
        logic [13:0] w;
        int          i;
        int          budget;
        bit          hs;
        do_reset();
        tick();
        got_q.delete(); exp_q.delete(); occ = 0; max_occ = 0;
        for (int m = 0; m < 30; m++) begin
            d = 8'($urandom);
            l = 4'($urandom_range(0, 15));
            exp_q.push_back({(l == 4'd0) ? 2'b11 : 2'b01, d, l, 2'b00});
            budget = 0;
            while (msg_ready !== 1'b1 && budget < 200) begin
                tick(); router_step(1'b0); budget++;
            end
            if (budget >= 200) begin
                total++; bad++; $display("FAIL rand_msg_timeout msg=%0d got=timeout want=msg_ready", m);
            end
            msg_valid = 1'b1; msg_dest = d; msg_len = l;
            tick(); router_step(1'b0);
            msg_valid = 1'b0;
            i = 0; budget = 0;
            w = 14'($urandom);
            while (i < int'(l) && budget < 500) begin
                data_valid = 1'($urandom_range(0, 3) != 0);
                data = w;
                hs = data_valid && data_ready;
                tick(); router_step(1'b0); budget++;
                if (hs) begin
                    exp_q.push_back({(i == int'(l) - 1) ? 2'b10 : 2'b00, w});
                    i++;
                    w = 14'($urandom);
                end
            end
            data_valid = 1'b0;
            if (budget >= 500) begin
                total++; bad++; $display("FAIL rand_data_timeout msg=%0d got=%0d want=%0d words", m, i, l);
            end
        end
        for (int k = 0; k < 40; k++) begin
            tick(); router_step(1'b1);
        end
        credit = 1'b0;
        tick();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL rand_flit%0d got=%h want=%h", k, got_q[k], exp_q[k]);
            end
        end
        total++; if (max_occ > 4) begin bad++; $display("FAIL rand_overflow got=%0d want<=4", max_occ); end
        total++; if (credit_err !== 1'b0) begin bad++; $display("FAIL rand_credit_err got=%b want=0", credit_err); end
        total++; if (dut.u_credit.count_r !== 3'd4) begin bad++; $display("FAIL rand_final_count got=%0d want=4", dut.u_credit.count_r); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_starve();
        test_same_cycle();
        test_credit_err();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
